// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 command sequencer: device response bytes,
// completion status codes and sequencer states.
package ps2_pkg;

    localparam logic [7:0] ACK       = 8'hFA;
    localparam logic [7:0] RESEND    = 8'hFE;
    localparam logic [7:0] BAT_OK    = 8'hAA;
    localparam logic [7:0] BAT_FAIL  = 8'hFC;
    localparam logic [7:0] CMD_RESET = 8'hFF;

    typedef enum logic [1:0] {
        STATUS_OK       = 2'd0,
        STATUS_NAK      = 2'd1,
        STATUS_TIMEOUT  = 2'd2,
        STATUS_TX_ERROR = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_ACK_WAIT,
        ST_BAT_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic {
        PHASE_CMD,
        PHASE_ARG
    } phase_t;

endpackage

// File: rtl/ps2_timeout_timer.sv
// Response timeout counter: cleared by the sequencer, counts while enabled and
// flags expiry when it reaches the selected limit minus one.
module ps2_timeout_timer #(
    parameter int CNT_W     = 26,
    parameter int LIMIT_ACK = 1_000_000,
    parameter int LIMIT_BAT = 40_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_sel_bat,
    output logic o_expired
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign w_limit   = i_sel_bat ? CNT_W'(LIMIT_BAT - 1) : CNT_W'(LIMIT_ACK - 1);
    assign o_expired = (r_count == w_limit);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Host-to-device PS/2 command sequencer: sends a command and optional argument,
// handles ACK/RESEND/BAT responses and forwards all other device bytes.
module ps2_cmd_sequencer
    import ps2_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1_000_000,
    parameter int BAT_TIMEOUT = 40_000_000,
    parameter int MAX_RETRY   = 3,
    parameter int CNT_W       = 26
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       req,
    input  logic [7:0] cmd_byte,
    input  logic [7:0] arg_byte,
    input  logic       has_arg,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    output logic [7:0] ps2_the_command,
    output logic       ps2_send_command,
    input  logic       ps2_command_was_sent,
    input  logic       ps2_error_timed_out,
    input  logic [7:0] ps2_received_data,
    input  logic       ps2_received_data_en,
    output logic [7:0] key_data,
    output logic       key_data_en
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t             r_state;
    phase_t             r_phase;
    status_t            r_status;
    logic [RETRY_W-1:0] r_retry;
    logic [7:0]         r_cmd;
    logic [7:0]         r_arg;
    logic               r_hasArg;
    logic               r_busy;
    logic               r_done;
    logic [7:0]         r_theCommand;
    logic               r_send;
    logic [7:0]         r_keyData;
    logic               r_keyEn;

    logic w_waiting;
    logic w_consumed;
    logic w_batEnter;
    logic w_timerClear;
    logic w_timerEnable;
    logic w_expired;

    assign w_waiting = (r_state == ST_ACK_WAIT) || (r_state == ST_BAT_WAIT);

    assign w_consumed = ps2_received_data_en &&
        (((r_state == ST_ACK_WAIT) && ((ps2_received_data == ACK) || (ps2_received_data == RESEND))) ||
         ((r_state == ST_BAT_WAIT) && ((ps2_received_data == BAT_OK) || (ps2_received_data == BAT_FAIL))));

    // The timer must already read zero in the first BAT_WAIT cycle, so clear on the ACK that leads there.
    assign w_batEnter = (r_state == ST_ACK_WAIT) && ps2_received_data_en && (ps2_received_data == ACK) &&
                        !((r_phase == PHASE_CMD) && r_hasArg) && (r_cmd == CMD_RESET);

    assign w_timerClear  = !w_waiting || w_batEnter;
    assign w_timerEnable = w_waiting && !ps2_received_data_en;

    ps2_timeout_timer #(
        .CNT_W     (CNT_W),
        .LIMIT_ACK (ACK_TIMEOUT),
        .LIMIT_BAT (BAT_TIMEOUT)
    ) u_timer (
        .clk       (CLOCK_50),
        .rst_n     (reset_n),
        .i_clear   (w_timerClear),
        .i_enable  (w_timerEnable),
        .i_sel_bat (r_state == ST_BAT_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_phase      <= PHASE_CMD;
            r_status     <= STATUS_OK;
            r_retry      <= '0;
            r_cmd        <= '0;
            r_arg        <= '0;
            r_hasArg     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_theCommand <= '0;
            r_send       <= 1'b0;
            r_keyData    <= '0;
            r_keyEn      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_keyEn <= ps2_received_data_en && !w_consumed;
            if (ps2_received_data_en && !w_consumed) begin
                r_keyData <= ps2_received_data;
            end

            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_cmd        <= cmd_byte;
                        r_arg        <= arg_byte;
                        r_hasArg     <= has_arg;
                        r_phase      <= PHASE_CMD;
                        r_retry      <= '0;
                        r_theCommand <= cmd_byte;
                        r_send       <= 1'b1;
                        r_busy       <= 1'b1;
                        r_status     <= STATUS_OK;
                        r_state      <= ST_TX;
                    end
                end

                ST_TX: begin
                    if (ps2_command_was_sent) begin
                        r_send  <= 1'b0;
                        r_state <= ST_ACK_WAIT;
                    end else if (ps2_error_timed_out) begin
                        r_send   <= 1'b0;
                        r_status <= STATUS_TX_ERROR;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end

                ST_ACK_WAIT: begin
                    if (ps2_received_data_en && (ps2_received_data == ACK)) begin
                        if ((r_phase == PHASE_CMD) && r_hasArg) begin
                            r_phase      <= PHASE_ARG;
                            r_retry      <= '0;
                            r_theCommand <= r_arg;
                            r_send       <= 1'b1;
                            r_state      <= ST_TX;
                        end else if (r_cmd == CMD_RESET) begin
                            r_state <= ST_BAT_WAIT;
                        end else begin
                            r_status <= STATUS_OK;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end else if (ps2_received_data_en && (ps2_received_data == RESEND)) begin
                        if (r_retry < RETRY_W'(MAX_RETRY)) begin
                            r_retry <= r_retry + 1'b1;
                            r_send  <= 1'b1;
                            r_state <= ST_TX;
                        end else begin
                            r_status <= STATUS_NAK;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end
                    end else if (!ps2_received_data_en && w_expired) begin
                        r_status <= STATUS_TIMEOUT;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end

                ST_BAT_WAIT: begin
                    if (ps2_received_data_en && (ps2_received_data == BAT_OK)) begin
                        r_status <= STATUS_OK;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (ps2_received_data_en && (ps2_received_data == BAT_FAIL)) begin
                        r_status <= STATUS_NAK;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (!ps2_received_data_en && w_expired) begin
                        r_status <= STATUS_TIMEOUT;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign status           = r_status;
    assign ps2_the_command  = r_theCommand;
    assign ps2_send_command = r_send;
    assign key_data         = r_keyData;
    assign key_data_en      = r_keyEn;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Directed self-checking bench for ps2_cmd_sequencer; the bench plays the PS/2
// controller, acknowledging each transmission 20 cycles after send rises.
module tb_ps2_cmd_sequencer;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic       req;
    logic [7:0] cmd_byte;
    logic [7:0] arg_byte;
    logic       has_arg;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic [7:0] ps2_the_command;
    logic       ps2_send_command;
    logic       ps2_command_was_sent;
    logic       ps2_error_timed_out;
    logic [7:0] ps2_received_data;
    logic       ps2_received_data_en;
    logic [7:0] key_data;
    logic       key_data_en;

    int checks    = 0;
    int failures  = 0;
    int doneCount = 0;
    int sendRises = 0;
    int doneBase;
    int sendBase;
    logic prevSend = 1'b0;

    ps2_cmd_sequencer #(
        .ACK_TIMEOUT (50),
        .BAT_TIMEOUT (100),
        .MAX_RETRY   (3),
        .CNT_W       (26)
    ) dut (
        .CLOCK_50             (CLOCK_50),
        .reset_n              (reset_n),
        .req                  (req),
        .cmd_byte             (cmd_byte),
        .arg_byte             (arg_byte),
        .has_arg              (has_arg),
        .busy                 (busy),
        .done                 (done),
        .status               (status),
        .ps2_the_command      (ps2_the_command),
        .ps2_send_command     (ps2_send_command),
        .ps2_command_was_sent (ps2_command_was_sent),
        .ps2_error_timed_out  (ps2_error_timed_out),
        .ps2_received_data    (ps2_received_data),
        .ps2_received_data_en (ps2_received_data_en),
        .key_data             (key_data),
        .key_data_en          (key_data_en)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Counts done pulses and rising edges of the send request.
    always @(posedge CLOCK_50) begin
        if (done) doneCount <= doneCount + 1;
        if (ps2_send_command && !prevSend) sendRises <= sendRises + 1;
        prevSend <= ps2_send_command;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] arg, input logic withArg);
        cmd_byte = cmd;
        arg_byte = arg;
        has_arg  = withArg;
        req      = 1'b1;
        @(negedge CLOCK_50);
        req      = 1'b0;
    endtask

    task automatic sendRx(input logic [7:0] data);
        ps2_received_data    = data;
        ps2_received_data_en = 1'b1;
        @(negedge CLOCK_50);
        ps2_received_data_en = 1'b0;
    endtask

    // Controller model: waits for send, then reports sent (or error) 20 cycles later.
    task automatic serviceTx(input string tag, input logic [7:0] expByte, input bit failTx);
        int waited = 0;
        while (!ps2_send_command && waited < 200) begin
            @(negedge CLOCK_50);
            waited++;
        end
        checkOutput({tag, "_sendSeen"}, 32'(ps2_send_command), 32'd1);
        checkOutput({tag, "_byte"}, 32'(ps2_the_command), 32'(expByte));
        repeat (19) @(negedge CLOCK_50);
        if (failTx) ps2_error_timed_out = 1'b1;
        else        ps2_command_was_sent = 1'b1;
        @(negedge CLOCK_50);
        ps2_error_timed_out  = 1'b0;
        ps2_command_was_sent = 1'b0;
        checkOutput({tag, "_sendDrop"}, 32'(ps2_send_command), 32'd0);
    endtask

    task automatic snapshot();
        doneBase = doneCount;
        sendBase = sendRises;
    endtask

    initial begin
        reset_n              = 1'b0;
        req                  = 1'b0;
        cmd_byte             = 8'h00;
        arg_byte             = 8'h00;
        has_arg              = 1'b0;
        ps2_command_was_sent = 1'b0;
        ps2_error_timed_out  = 1'b0;
        ps2_received_data    = 8'h00;
        ps2_received_data_en = 1'b0;
        tick(3);

        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_status", 32'(status), 32'd0);
        checkOutput("rst_send", 32'(ps2_send_command), 32'd0);
        checkOutput("rst_cmd", 32'(ps2_the_command), 32'd0);
        checkOutput("rst_keyEn", 32'(key_data_en), 32'd0);
        checkOutput("rst_key", 32'(key_data), 32'd0);
        reset_n = 1'b1;
        tick(2);

        $display("[TB] scenario 1: command with argument");
        snapshot();
        applyStimulus(8'hED, 8'h07, 1'b1);
        checkOutput("s1_busy", 32'(busy), 32'd1);
        serviceTx("s1_cmd", 8'hED, 1'b0);
        sendRx(8'hFA);
        serviceTx("s1_arg", 8'h07, 1'b0);
        checkOutput("s1_doneEarly", 32'(done), 32'd0);
        sendRx(8'hFA);
        checkOutput("s1_done", 32'(done), 32'd1);
        checkOutput("s1_status", 32'(status), 32'd0);
        tick(1);
        checkOutput("s1_doneOnce", 32'(done), 32'd0);
        checkOutput("s1_busyIdle", 32'(busy), 32'd0);
        tick(2);
        checkOutput("s1_doneCount", 32'(doneCount - doneBase), 32'd1);
        checkOutput("s1_sendRises", 32'(sendRises - sendBase), 32'd2);

        $display("[TB] scenario 2a: two resends then ack");
        snapshot();
        applyStimulus(8'hF4, 8'h00, 1'b0);
        serviceTx("s2a_tx1", 8'hF4, 1'b0);
        sendRx(8'hFE);
        serviceTx("s2a_tx2", 8'hF4, 1'b0);
        sendRx(8'hFE);
        serviceTx("s2a_tx3", 8'hF4, 1'b0);
        sendRx(8'hFA);
        checkOutput("s2a_done", 32'(done), 32'd1);
        checkOutput("s2a_status", 32'(status), 32'd0);
        tick(3);
        checkOutput("s2a_sendRises", 32'(sendRises - sendBase), 32'd3);

        $display("[TB] scenario 2b: resend limit");
        snapshot();
        applyStimulus(8'hF4, 8'h00, 1'b0);
        serviceTx("s2b_tx1", 8'hF4, 1'b0);
        sendRx(8'hFE);
        serviceTx("s2b_tx2", 8'hF4, 1'b0);
        sendRx(8'hFE);
        serviceTx("s2b_tx3", 8'hF4, 1'b0);
        sendRx(8'hFE);
        serviceTx("s2b_tx4", 8'hF4, 1'b0);
        sendRx(8'hFE);
        checkOutput("s2b_done", 32'(done), 32'd1);
        checkOutput("s2b_status", 32'(status), 32'd1);
        tick(3);
        checkOutput("s2b_sendRises", 32'(sendRises - sendBase), 32'd4);
        checkOutput("s2b_statusHeld", 32'(status), 32'd1);

        $display("[TB] scenario 3a: reset with BAT ok");
        applyStimulus(8'hFF, 8'h00, 1'b0);
        checkOutput("s3a_statusCleared", 32'(status), 32'd0);
        serviceTx("s3a_tx", 8'hFF, 1'b0);
        sendRx(8'hFA);
        checkOutput("s3a_noDoneAtAck", 32'(done), 32'd0);
        checkOutput("s3a_busy", 32'(busy), 32'd1);
        tick(3);
        sendRx(8'h5A);
        checkOutput("s3a_fwdEn", 32'(key_data_en), 32'd1);
        checkOutput("s3a_fwdData", 32'(key_data), 32'h5A);
        sendRx(8'hAA);
        checkOutput("s3a_done", 32'(done), 32'd1);
        checkOutput("s3a_status", 32'(status), 32'd0);
        checkOutput("s3a_batNotFwd", 32'(key_data_en), 32'd0);
        tick(2);

        $display("[TB] scenario 3b: BAT timeout");
        applyStimulus(8'hFF, 8'h00, 1'b0);
        serviceTx("s3b_tx", 8'hFF, 1'b0);
        sendRx(8'hFA);
        tick(99);
        checkOutput("s3b_notYet", 32'(done), 32'd0);
        tick(1);
        checkOutput("s3b_done", 32'(done), 32'd1);
        checkOutput("s3b_status", 32'(status), 32'd2);
        tick(2);

        $display("[TB] scenario 4a: transmit error");
        applyStimulus(8'hF3, 8'h00, 1'b0);
        serviceTx("s4a_tx", 8'hF3, 1'b1);
        checkOutput("s4a_done", 32'(done), 32'd1);
        checkOutput("s4a_status", 32'(status), 32'd3);
        tick(2);

        $display("[TB] scenario 4b: ack timeout");
        applyStimulus(8'hF3, 8'h00, 1'b0);
        serviceTx("s4b_tx", 8'hF3, 1'b0);
        tick(49);
        checkOutput("s4b_notYet", 32'(done), 32'd0);
        tick(1);
        checkOutput("s4b_done", 32'(done), 32'd1);
        checkOutput("s4b_status", 32'(status), 32'd2);
        tick(2);

        $display("[TB] scenario 5: forwarding");
        checkOutput("s5_idleBefore", 32'(key_data_en), 32'd0);
        sendRx(8'h1C);
        checkOutput("s5_idleEn", 32'(key_data_en), 32'd1);
        checkOutput("s5_idleData", 32'(key_data), 32'h1C);
        tick(1);
        checkOutput("s5_idleStrobe", 32'(key_data_en), 32'd0);
        applyStimulus(8'hF4, 8'h00, 1'b0);
        serviceTx("s5_tx", 8'hF4, 1'b0);
        sendRx(8'h1C);
        checkOutput("s5_waitEn", 32'(key_data_en), 32'd1);
        checkOutput("s5_waitData", 32'(key_data), 32'h1C);
        checkOutput("s5_stillBusy", 32'(busy), 32'd1);
        sendRx(8'hFA);
        checkOutput("s5_ackNotFwd", 32'(key_data_en), 32'd0);
        checkOutput("s5_keyHeld", 32'(key_data), 32'h1C);
        checkOutput("s5_done", 32'(done), 32'd1);
        checkOutput("s5_status", 32'(status), 32'd0);
        tick(2);

        $display("[TB] scenario 6: asynchronous reset mid-transmission");
        snapshot();
        applyStimulus(8'hF4, 8'h00, 1'b0);
        tick(5);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("s6_sendAsync", 32'(ps2_send_command), 32'd0);
        checkOutput("s6_busyAsync", 32'(busy), 32'd0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        tick(4);
        checkOutput("s6_noDone", 32'(doneCount - doneBase), 32'd0);
        snapshot();
        applyStimulus(8'hF4, 8'h00, 1'b0);
        applyStimulus(8'hF3, 8'h00, 1'b0);
        serviceTx("s6_tx", 8'hF4, 1'b0);
        sendRx(8'hFA);
        checkOutput("s6_done", 32'(done), 32'd1);
        checkOutput("s6_status", 32'(status), 32'd0);
        applyStimulus(8'hF3, 8'h00, 1'b0);
        tick(3);
        checkOutput("s6_doneReqIgnored", 32'(ps2_send_command), 32'd0);
        checkOutput("s6_idleBusy", 32'(busy), 32'd0);
        checkOutput("s6_doneCount", 32'(doneCount - doneBase), 32'd1);
        checkOutput("s6_sendRises", 32'(sendRises - sendBase), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
Sequences host-to-device PS/2 transactions over the existing PS/2 controller: sends a command byte and an optional argument byte, and collects the device responses (ACK 0xFA, RESEND 0xFE, BAT 0xAA/0xFC). It retries on RESEND, times out missing responses, and reports one completion status per request. It sits between user logic (keys/switches or a higher FSM) and the PS/2 controller. Device bytes that are not consumed as responses are forwarded as a clean scan-code stream.

Parameters:
ACK_TIMEOUT, 1_000_000, cycles to wait for ACK/RESEND after each byte is sent (20 ms at 50 MHz)
BAT_TIMEOUT, 40_000_000, cycles to wait for the BAT result after an acknowledged 0xFF (800 ms)
MAX_RETRY, 3, RESEND retries allowed per byte before reporting NAK
CNT_W, 26, timer width; must hold max(ACK_TIMEOUT, BAT_TIMEOUT)

Ports:
CLOCK_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  1  start request; sampled only in IDLE
cmd_byte  in  8  command byte
arg_byte  in  8  argument byte
has_arg  in  1  send arg_byte after cmd_byte is ACKed
busy  out  1  high from the cycle after an accepted req through the DONE cycle
done  out  1  one-cycle completion pulse
status  out  2  0 OK, 1 NAK, 2 TIMEOUT, 3 TX_ERROR; valid with done, held until the next accepted req
ps2_the_command  out  8  byte to the controller
ps2_send_command  out  1  level send request to the controller
ps2_command_was_sent  in  1  controller: byte transmitted
ps2_error_timed_out  in  1  controller: transmission failed
ps2_received_data  in  8  controller received byte
ps2_received_data_en  in  1  controller received strobe
key_data  out  8  forwarded scan code
key_data_en  out  1  one-cycle forward strobe

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset is asynchronous, so it is effective mid-transaction; ps2_send_command drops immediately and no done pulse follows.
- All outputs are registered.
- IDLE: on req, latch cmd_byte, arg_byte and has_arg; set phase=CMD, retry=0; go to TX.
- TX: ps2_send_command=1; ps2_the_command = arg_byte when phase=ARG, else cmd_byte.
  - ps2_command_was_sent -> ACK_WAIT, with send low on the next cycle.
  - ps2_error_timed_out -> DONE, status=3.
  - Between any two transmissions, send stays low for at least 1 cycle so the controller can return to idle.
- ACK_WAIT: the timer clears on entry and increments each cycle.
  - rx 0xFA, phase=CMD and has_arg -> phase=ARG, retry=0, go to TX.
  - rx 0xFA and latched cmd=0xFF -> BAT_WAIT.
  - rx 0xFA otherwise -> DONE, status=0.
  - rx 0xFE with retry<MAX_RETRY -> retry++, back to TX with the same byte.
  - rx 0xFE with retry=MAX_RETRY -> DONE, status=1.
  - Any other rx byte is forwarded and leaves state and timer unchanged.
  - Timer reaching ACK_TIMEOUT-1 -> DONE, status=2.
- BAT_WAIT: the timer clears on entry.
  - rx 0xAA -> DONE, status=0.
  - rx 0xFC -> DONE, status=1.
  - Other bytes are forwarded.
  - Timer reaching BAT_TIMEOUT-1 -> DONE, status=2.
- DONE: done=1 for one cycle, then IDLE. busy=0 in IDLE.
- Simultaneous rx strobe and timeout in the same cycle: the rx byte wins.
- req while busy: ignored and not queued.
- A req that falls in the DONE cycle is ignored.
- Forwarding:
  - In IDLE, TX and DONE, every received byte appears on key_data, with key_data_en one cycle after ps2_received_data_en.
  - In the wait states, only bytes consumed as responses are suppressed.

Decomposition:
- Shared package ps2_pkg holds:
  - response constants: ACK 0xFA, RESEND 0xFE, BAT_OK 0xAA, BAT_FAIL 0xFC, CMD_RESET 0xFF
  - status enum: OK, NAK, TIMEOUT, TX_ERROR
  - state enum: IDLE, TX, ACK_WAIT, BAT_WAIT, DONE
- One natural sub-module, ps2_timeout_timer: clear/enable inputs, CNT_W counter, compare against a selectable limit, expired output.

Test Plan:
Every scenario uses a bench model of the PS/2 controller that asserts command_was_sent 20 cycles after send rises, and supplies rx bytes on demand.
1. req with cmd=0xED, arg=0x07, has_arg=1; model replies 0xFA after each byte -> ps2_the_command shows 0xED then 0xO7, two send pulses with a low gap between them, single done, status=0.
2. cmd=0xF4; replies FE, FE, FA -> three transmissions of 0xF4, status=0. Replies FE×4 -> four transmissions, status=1.
3. cmd=0xFF with BAT_TIMEOUT=100; reply FA then AA -> status=0. Reply FA and no AA -> done exactly 100 cycles after entering BAT_WAIT, status=2.
4. cmd=0xF3; model asserts ps2_error_timed_out instead of sent -> send low next cycle, done, status=3. No FA reply with ACK_TIMEOUT=50 -> status=2 at cycle 50.
5. Idle rx 0x1C -> key_data=0x1C with a one-cycle strobe. During ACK_WAIT rx 0x1C then 0xFA -> 0x1C forwarded, 0xFA not.
6. reset_n pulsed low mid-TX -> send and busy drop asynchronously, no done pulse. A following req with 0xF4/FA completes with status=0. A second req issued while busy is ignored.
